// File: rtl/spim_pkg.sv
`default_nettype none
// ---------------------------------------------------------------
// spim_pkg : shared state encoding and word sizes for spi_mult_master
// Rev 1.0
// ---------------------------------------------------------------
package spim_pkg;
  localparam int SPIM_WORD_BITS   = 8;
  localparam int SPIM_NIBBLE_BITS = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    TX    = 3'd2,
    GAP   = 3'd3,
    RX    = 3'd4,
    HOLD  = 3'd5
  } spim_state_e;
endpackage
`default_nettype wire

// File: rtl/spim_clkgen.sv
`default_nettype none
// ---------------------------------------------------------------
// spim_clkgen : half-period counter; ticks every CLKDIV cycles, flips SCLK phase
// Rev 1.0
// ---------------------------------------------------------------
module spim_clkgen #(
  parameter int CLKDIV = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick,
  output logic phase
);
  localparam int CW = $clog2(CLKDIV);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(CLKDIV - 1));

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (tick) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: rtl/spi_mult_master.sv
`default_nettype none
// ---------------------------------------------------------------
// spi_mult_master : SPI initiator for one 4x4 multiply transaction.
// Optional SPIM_RESULT_CHECK_EN adds the err output. Rev 1.0
// ---------------------------------------------------------------
module spi_mult_master #(
  parameter int CLKDIV      = 8,
  parameter int WAIT_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] product,
  output logic       SCLK,
  output logic       MOSI,
  output logic       CS,
  input  logic       MISO
`ifdef SPIM_RESULT_CHECK_EN
  ,
  output logic       err
`endif
);
  import spim_pkg::*;

  localparam int MAXC  = (CLKDIV > WAIT_CYCLES) ? CLKDIV : WAIT_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);

  spim_state_e               state, state_next;
  logic [CNT_W-1:0]          cnt;
  logic [2:0]                bit_cnt;
  logic [SPIM_WORD_BITS-1:0] tx_sr, rx_sr;
  logic                      sclk_en, tick, phase, rise, fall, last_bit;

  assign sclk_en  = (state == TX) || (state == RX);
  assign rise     = tick && !phase;
  assign fall     = tick && phase;
  assign last_bit = (bit_cnt == 3'd7);
  assign SCLK     = phase;

  spim_clkgen #(.CLKDIV(CLKDIV)) u_clkgen (
    .clk   (clk),
    .reset (reset),
    .en    (sclk_en),
    .tick  (tick),
    .phase (phase)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = SETUP;
      SETUP: if (cnt == CNT_W'(CLKDIV - 1)) state_next = TX;
      TX:    if (fall && last_bit) state_next = (WAIT_CYCLES == 0) ? RX : GAP;
      GAP:   if (cnt == CNT_W'(WAIT_CYCLES - 1)) state_next = RX;
      RX:    if (fall && last_bit) state_next = HOLD;
      HOLD:  if (cnt == CNT_W'(CLKDIV - 1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    CS   = (state == IDLE);
    busy = (state != IDLE);
  end

`ifdef SPIM_RESULT_CHECK_EN
  logic [SPIM_WORD_BITS-1:0] op_word;
  logic [SPIM_WORD_BITS-1:0] expected;
  assign expected = SPIM_WORD_BITS'(op_word[SPIM_NIBBLE_BITS-1:0]) *
                    SPIM_WORD_BITS'(op_word[SPIM_WORD_BITS-1:SPIM_NIBBLE_BITS]);

  always_ff @(posedge clk) begin
    if (reset) begin
      op_word <= '0;
      err     <= 1'b0;
    end else begin
      if (state == IDLE && start) op_word <= {b, a};
      if (state == HOLD && state_next == IDLE) err <= (rx_sr != expected);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      bit_cnt <= 3'd0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      product <= '0;
      MOSI    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      // cnt times SETUP, GAP and HOLD; it restarts on every state change
      if (state_next != state || sclk_en || state == IDLE) cnt <= '0;
      else                                                 cnt <= cnt + 1'b1;

      case (state)
        IDLE: begin
          MOSI <= 1'b0;
          if (start) begin
            tx_sr   <= {b, a};
            bit_cnt <= 3'd0;
          end
        end
        SETUP: if (state_next == TX) MOSI <= tx_sr[SPIM_WORD_BITS-1];
        TX: if (fall) begin
          if (last_bit) begin
            MOSI    <= 1'b0;
            bit_cnt <= 3'd0;
          end else begin
            MOSI    <= tx_sr[SPIM_WORD_BITS-2];
            tx_sr   <= tx_sr << 1;
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        RX: begin
          if (rise) rx_sr[3'd7 - bit_cnt] <= MISO;
          if (fall) bit_cnt <= last_bit ? 3'd0 : bit_cnt + 3'd1;
        end
        HOLD: if (state_next == IDLE) begin
          product <= rx_sr;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_spi_mult_master.sv
`default_nettype none
// ---------------------------------------------------------------
// tb_spi_mult_master : vector table, random transactions and corner sequences
// against two configurations (8/32 and 2/0). Rev 1.0
// ---------------------------------------------------------------
module tb_spi_mult_master;
  localparam int CD0 = 8, W0 = 32, CD1 = 2, W1 = 0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]      start, busy, done, sclk, mosi, cs, miso;
  logic [1:0][3:0] a, b;
  logic [1:0][7:0] product, resp, mosi_cap;
`ifdef SPIM_RESULT_CHECK_EN
  logic [1:0]      err;
`endif

  int rcnt[2]      = '{0, 0};
  int cs_falls[2]  = '{0, 0};
  int sclk_viol[2] = '{0, 0};
  logic [1:0] cs_prev = 2'b11, sclk_prev = 2'b00;
  int n_vec = 0, n_bad = 0;

  spi_mult_master #(.CLKDIV(CD0), .WAIT_CYCLES(W0)) dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .a(a[0]), .b(b[0]),
    .busy(busy[0]), .done(done[0]), .product(product[0]),
    .SCLK(sclk[0]), .MOSI(mosi[0]), .CS(cs[0]), .MISO(miso[0])
`ifdef SPIM_RESULT_CHECK_EN
    , .err(err[0])
`endif
  );

  spi_mult_master #(.CLKDIV(CD1), .WAIT_CYCLES(W1)) dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .a(a[1]), .b(b[1]),
    .busy(busy[1]), .done(done[1]), .product(product[1]),
    .SCLK(sclk[1]), .MOSI(mosi[1]), .CS(cs[1]), .MISO(miso[1])
`ifdef SPIM_RESULT_CHECK_EN
    , .err(err[1])
`endif
  );

  // Peripheral model: rises 0..7 capture MOSI, rises 8..15 are answered from resp, MSB first
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (cs_prev[k] && !cs[k]) cs_falls[k] <= cs_falls[k] + 1;
      if (cs[k] && sclk[k]) sclk_viol[k] <= sclk_viol[k] + 1;
      if (cs[k]) rcnt[k] <= 0;
      else if (sclk[k] && !sclk_prev[k]) begin
        if (rcnt[k] < 8) mosi_cap[k] <= {mosi_cap[k][6:0], mosi[k]};
        rcnt[k] <= rcnt[k] + 1;
      end
    end
    cs_prev   <= cs;
    sclk_prev <= sclk;
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      miso[k] = 1'b0;
      if (rcnt[k] >= 8 && rcnt[k] < 16) miso[k] = resp[k][15 - rcnt[k]];
    end
  end

  typedef struct {
    logic [3:0] a, b;
    logic [7:0] resp, exp_mosi, exp_prod;
    logic       exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input int k);
    return (k == 0) ? 34 * CD0 + W0 : 34 * CD1 + W1;
  endfunction

  task automatic wait_done(input int k, output int lat);
    lat = 0;
    while (done[k] !== 1'b1 && lat < 3000) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 3000) begin
      n_vec++;
      n_bad++;
      $display("FAIL timeout waiting for done on instance %0d", k);
    end
  endtask

  task automatic run_txn(input int k, input logic [3:0] ta, input logic [3:0] tb_,
                         input logic [7:0] r, input logic [7:0] e_mosi,
                         input logic [7:0] e_prod, input logic e_err);
    int lat;
    @(negedge clk);
    a[k] = ta; b[k] = tb_; resp[k] = r; start[k] = 1'b1;
    @(posedge clk); #1;
    start[k] = 1'b0;
    a[k] = 4'($urandom); b[k] = 4'($urandom);
    chk("busy_rise", busy[k], 1'b1);
    chk("cs_fall", cs[k], 1'b0);
    wait_done(k, lat);
    chk("done_latency", lat, exp_lat(k));
    chk("product", product[k], e_prod);
    chk("mosi_bits", mosi_cap[k], e_mosi);
    chk("cs_at_done", cs[k], 1'b1);
    chk("busy_at_done", busy[k], 1'b0);
`ifdef SPIM_RESULT_CHECK_EN
    chk("err", err[k], e_err);
`else
    if (e_err) ;
`endif
    @(posedge clk); #1;
    chk("done_pulse_width", done[k], 1'b0);
    chk("product_hold", product[k], e_prod);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    int lat, f0, dones;
    logic [3:0] ra, rb;
    logic [7:0] rr, ref_prod;
    int k;

    tbl[0] = '{4'h3, 4'h5, 8'h0F, 8'h53, 8'h0F, 1'b0};
    tbl[1] = '{4'hF, 4'hF, 8'hE1, 8'hFF, 8'hE1, 1'b0};
    tbl[2] = '{4'hF, 4'hF, 8'h00, 8'hFF, 8'h00, 1'b1};
    tbl[3] = '{4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[4] = '{4'hA, 4'h6, 8'h3C, 8'h6A, 8'h3C, 1'b0};
    tbl[5] = '{4'h1, 4'h8, 8'hFF, 8'h81, 8'hFF, 1'b1};

    start = '0; a = '0; b = '0; resp = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    chk("reset_cs", cs[0], 1'b1);
    chk("reset_sclk", sclk[0], 1'b0);
    chk("reset_mosi", mosi[0], 1'b0);
    chk("reset_busy", busy[0], 1'b0);
    chk("reset_done", done[0], 1'b0);
    chk("reset_product", product[0], 8'h00);

    for (int i = 0; i < 6; i++)
      run_txn(0, tbl[i].a, tbl[i].b, tbl[i].resp, tbl[i].exp_mosi, tbl[i].exp_prod, tbl[i].exp_err);
    for (int i = 0; i < 3; i++)
      run_txn(1, tbl[i].a, tbl[i].b, tbl[i].resp, tbl[i].exp_mosi, tbl[i].exp_prod, tbl[i].exp_err);

    // Reset in the middle of GAP: immediate abort, product cleared, no done
    @(negedge clk);
    a[0] = 4'h7; b[0] = 4'h9; resp[0] = 8'h3F; start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (149) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_cs", cs[0], 1'b1);
    chk("abort_sclk", sclk[0], 1'b0);
    chk("abort_busy", busy[0], 1'b0);
    chk("abort_product", product[0], 8'h00);
    @(negedge clk); reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (done[0]) dones++;
    end
    chk("abort_no_done", dones, 0);
    run_txn(0, 4'h7, 4'h9, 8'h3F, 8'h97, 8'h3F, 1'b0);

    // start held high: restart exactly one cycle after done
    f0 = cs_falls[0];
    @(negedge clk);
    a[0] = 4'h2; b[0] = 4'h3; resp[0] = 8'h06; start[0] = 1'b1;
    @(posedge clk); #1;
    wait_done(0, lat);
    chk("held_first_latency", lat, exp_lat(0));
    @(posedge clk); #1;
    chk("held_restart_cs", cs[0], 1'b0);
    chk("held_restart_busy", busy[0], 1'b1);
    wait_done(0, lat);
    start[0] = 1'b0;
    chk("held_second_latency", lat, exp_lat(0));
    chk("held_product", product[0], 8'h06);
    chk("held_cs_falls", cs_falls[0] - f0, 2);
    repeat (3) @(posedge clk);

    // Random transactions against the behavioural peripheral/product model
    for (int i = 0; i < 16; i++) begin
      k  = int'($urandom_range(0, 1));
      ra = 4'($urandom);
      rb = 4'($urandom);
      ref_prod = 8'(ra) * 8'(rb);
      rr = ($urandom_range(0, 1) == 1) ? ref_prod : 8'($urandom);
      run_txn(k, ra, rb, rr, {rb, ra}, rr, rr != ref_prod);
    end

    chk("sclk_idle_inst0", sclk_viol[0], 0);
    chk("sclk_idle_inst1", sclk_viol[1], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/spi_mult_master.md
# spi_mult_master

SPI initiator that drives one multiply transaction into the SPI multiplier peripheral. It shifts two 4-bit operands out on MOSI and waits a fixed gap for the peripheral's multiplier. It then clocks the 8-bit product back on MISO and presents it to the local host with a done pulse. It sits on the host side of the board, opposite the peripheral, with SCLK slow enough for the peripheral's input conditioners.

## Interface
Parameters:
- CLKDIV, 8, clk cycles per SCLK half-period; legal range ≥2.
- WAIT_CYCLES, 32, clk cycles CS stays low with SCLK idle between write and read phases; 0 is legal and skips the gap.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a transaction; sampled only in IDLE.
- a  in  4  operand A, sent in the low nibble.
- b  in  4  operand B, sent in the high nibble.
- busy  out  1  high from start-accept until done.
- done  out  1  one-cycle pulse; product valid.
- product  out  8  last received result; held until the next done.
- SCLK  out  1  SPI clock, idle low.
- MOSI  out  1  serial data to the peripheral.
- CS  out  1  chip select, active low, idle high.
- MISO  in  1  serial data from the peripheral.

## Operation
- States: IDLE → SETUP → TX → GAP → RX → HOLD → IDLE. The done pulse is issued on the HOLD→IDLE transition.
- IDLE:
  - CS=1, SCLK=0, MOSI=0.
  - On start=1, latch shift word {b,a}, clear bit counter, drive CS=0, go to SETUP.
- SETUP: CS low with SCLK low for CLKDIV cycles; MOSI = word[7]; go to TX.
- TX: 8 bits, MSB first, so b[3] goes first and a[0] last.
  - Each bit is a low half-period then a high half-period, CLKDIV cycles each.
  - MOSI changes only at the falling SCLK edge, or at SETUP exit for bit 7.
  - The peripheral samples MOSI on the rising edge.
- GAP: SCLK low, CS low, MOSI=0, for WAIT_CYCLES cycles. If WAIT_CYCLES=0, go directly to RX.
- RX: 8 bits, MSB first.
  - Each bit is a low half-period then a high half-period.
  - MISO is sampled into shift register bit position (7 - n) on the clk cycle where SCLK rises.
- HOLD: SCLK low for CLKDIV cycles, then:
  - product ← received byte,
  - done=1 for one cycle,
  - CS=1,
  - back to IDLE.
- start while busy=1 is ignored; a and b are not re-sampled during a transaction.
- Reset values: CS=1, SCLK=0, MOSI=0, busy=0, done=0, product=8'h00, state IDLE.
- Reset mid-transaction aborts in the same cycle: CS=1, SCLK=0, product cleared, no done pulse.

## Timing
- start sampled at edge 0; CS falls at edge 0 and busy rises at edge 0.
- First SCLK rise at edge 2·CLKDIV; eighth TX rise at edge 16·CLKDIV.
- RX starts at edge 17·CLKDIV + WAIT_CYCLES.
- done=1 and CS=1 at edge 34·CLKDIV + WAIT_CYCLES; busy falls at the same edge.
  - With defaults this is 304 cycles.
- A new start is accepted on the cycle after done. Back-to-back transactions therefore have CS high for at least 1 cycle.
- SCLK duty is exactly 50%; SCLK never toggles while CS=1.

## Configuration
- SPIM_RESULT_CHECK_EN defined:
  - Adds output err (1 bit, reset 0).
  - When done pulses, err = (received product != a_latched·b_latched, 8-bit unsigned); err holds until the next done or reset.
  - Costs one 4×4 combinational multiplier.
- Not defined: no err port, no checker logic; all other behaviour is identical.

## Structure
- Package spim_pkg holds:
  - state enum (IDLE, SETUP, TX, GAP, RX, HOLD),
  - constant SPIM_WORD_BITS = 8,
  - constant SPIM_NIBBLE_BITS = 4.
- Sub-module spim_clkgen is natural. It is a half-period counter with enable that outputs a one-cycle tick every CLKDIV cycles plus the current SCLK phase. It is reset to phase low whenever its enable drops.
- Top level owns the FSM, bit counter (0–7), gap counter, TX/RX shift registers and product register.

## Test plan
- Reset, then idle 50 cycles → CS=1, SCLK=0, MOSI=0, busy=0, done=0, product=0.
- a=4'h3, b=4'h5 with a bus model of the peripheral returning 8'h0F:
  - MOSI bits sampled at SCLK rises are 0101_0011;
  - done at cycle 304;
  - product=8'h0F.
- a=4'hF, b=4'hF, model returns 8'hE1 → product=8'hE1; err=0 when SPIM_RESULT_CHECK_EN is defined. With the model forced to return 8'h00 → err=1.
- start held high continuously → second transaction's CS falls exactly 1 cycle after the first done; no start is accepted while busy.
- Assert reset at cycle 150 (mid-GAP) → CS=1 and SCLK=0 in the next cycle, no done pulse; a subsequent start completes normally.
- Configurations CLKDIV=2 with WAIT_CYCLES=0 → done at cycle 68; SCLK period 4 cycles; CS low throughout with no idle gap.
